// File: rtl/bitwise_result_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_pack_pkg
//  Purpose  : Shared field indices, FSM encoding and record layout for the
//             bitwise result packer.
//  Revision : 1.0
// ============================================================================
package bitwise_pack_pkg;

  localparam int OR_IDX     = 0;
  localparam int AND_IDX    = 1;
  localparam int XOR_IDX    = 2;
  localparam int NUM_FIELDS = 3;
  localparam int DEF_W      = 8;

  localparam logic [NUM_FIELDS-1:0] FULL_MASK = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } state_e;

  // Record layout at the default field width; wider builds use the same
  // ordering as a flat vector of rec_width(W) bits.
  typedef struct packed {
    logic [NUM_FIELDS-1:0] mask;
    logic [DEF_W-1:0]      xor_f;
    logic [DEF_W-1:0]      and_f;
    logic [DEF_W-1:0]      or_f;
  } rec_t;

  function automatic int rec_width(input int w);
    return NUM_FIELDS + NUM_FIELDS * w;
  endfunction

  function automatic logic [1:0] strobe_count(input logic [NUM_FIELDS-1:0] v);
    return {1'b0, v[OR_IDX]} + {1'b0, v[AND_IDX]} + {1'b0, v[XOR_IDX]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitwise_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_result_packer_if
//  Purpose  : Field strobes in, packed record valid/ready out, drop counter.
//  Revision : 1.0
// ============================================================================
interface bitwise_result_packer_if
  import bitwise_pack_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
);

  logic                  or_vld;
  logic [W-1:0]          or_data;
  logic                  and_vld;
  logic [W-1:0]          and_data;
  logic                  xor_vld;
  logic [W-1:0]          xor_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*W-1:0]        out_data;
  logic [NUM_FIELDS-1:0] out_mask;
  logic [CNT_W-1:0]      drop_cnt;

  // Upstream/consumer side
  modport master (
    output or_vld, or_data, and_vld, and_data, xor_vld, xor_data, out_ready,
    input  in_ready, out_valid, out_data, out_mask, drop_cnt
  );

  // Packer side
  modport slave (
    input  or_vld, or_data, and_vld, and_data, xor_vld, xor_data, out_ready,
    output in_ready, out_valid, out_data, out_mask, drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/bitwise_result_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_pack_fifo
//  Purpose  : Two-entry register FIFO; push while full is accepted when a
//             pop happens on the same edge.
//  Revision : 1.0
// ============================================================================
module bitwise_pack_fifo #(
  parameter int DW = 27
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          push_i,
  input  wire logic [DW-1:0] push_data_i,
  input  wire logic          pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [DW-1:0]      head_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          w_do_push;
  logic          w_do_pop;

  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);
  assign head_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitwise_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_result_packer
//  Purpose  : Gathers staggered OR/AND/XOR results into one record, flushes
//             partials on timeout or duplicate, buffers two records.
//  Revision : 1.0
// ============================================================================
module bitwise_result_packer
  import bitwise_pack_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input wire logic               clk,
  input wire logic               rst_n,
  bitwise_result_packer_if.slave bus
);

  localparam int               REC_W    = rec_width(W);
  localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [NUM_FIELDS-1:0] mask_q, mask_d;
  logic [3*W-1:0]        data_q, data_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic                  w_in_ready;
  logic [NUM_FIELDS-1:0] w_stb;
  logic [NUM_FIELDS-1:0] w_cap;
  logic [NUM_FIELDS-1:0] w_dup;
  logic [NUM_FIELDS-1:0] w_merged_mask;
  logic [3*W-1:0]        w_stb_data;
  logic [3*W-1:0]        w_merged_data;
  logic                  w_push;
  logic [REC_W-1:0]      w_push_rec;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_slot;
  logic [REC_W-1:0]      w_head;
  logic [1:0]            w_drop_n;
  logic [CNT_W:0]        w_drop_sum;

  assign w_stb         = {bus.xor_vld, bus.and_vld, bus.or_vld};
  assign w_stb_data    = {bus.xor_data, bus.and_data, bus.or_data};
  assign w_in_ready    = (state_q != STALL);
  assign w_cap         = w_in_ready ? w_stb : '0;
  assign w_dup         = w_cap & mask_q;
  assign w_merged_mask = mask_q | w_cap;
  assign w_pop         = !w_empty && bus.out_ready;
  // A pop on the same edge frees a slot even when the FIFO reads full.
  assign w_slot        = !w_full || w_pop;

  always_comb begin
    w_merged_data = data_q;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (w_cap[i]) begin
        w_merged_data[i*W +: W] = w_stb_data[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    data_d     = data_q;
    timer_d    = timer_q;
    w_push     = 1'b0;
    w_push_rec = {mask_q, data_q};
    case (state_q)
      IDLE: begin
        if (w_cap != '0) begin
          mask_d  = w_cap;
          data_d  = w_merged_data;
          timer_d = '0;
          if (w_cap == FULL_MASK) begin
            w_push_rec = {FULL_MASK, w_merged_data};
            if (w_slot) begin
              w_push = 1'b1;
              mask_d = '0;
            end else begin
              state_d = STALL;
            end
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (w_dup != '0) begin
          // Flush the held record; the repeated field seeds a fresh one.
          if (w_slot) begin
            w_push  = 1'b1;
            mask_d  = w_cap;
            data_d  = w_merged_data;
            timer_d = '0;
          end else begin
            state_d = STALL;
          end
        end else if (w_merged_mask == FULL_MASK) begin
          w_push_rec = {FULL_MASK, w_merged_data};
          data_d     = w_merged_data;
          if (w_slot) begin
            w_push  = 1'b1;
            mask_d  = '0;
            state_d = IDLE;
          end else begin
            mask_d  = FULL_MASK;
            state_d = STALL;
          end
        end else if (w_cap != '0) begin
          mask_d  = w_merged_mask;
          data_d  = w_merged_data;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          if (w_slot) begin
            w_push  = 1'b1;
            mask_d  = '0;
            state_d = IDLE;
          end else begin
            state_d = STALL;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STALL: begin
        if (w_slot) begin
          w_push  = 1'b1;
          mask_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  assign w_drop_n   = w_in_ready ? 2'd0 : strobe_count(w_stb);
  assign w_drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(w_drop_n);
  assign drop_cnt_d = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  bitwise_pack_fifo #(
    .DW (REC_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_data_i (w_push_rec),
    .pop_i       (w_pop),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head[3*W-1:0];
  assign bus.out_mask  = w_head[REC_W-1 -: NUM_FIELDS];
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitwise_result_packer
//  Purpose  : Directed scenarios plus randomized records against a queue model.
//  Revision : 1.0
// ============================================================================
module tb_bitwise_result_packer;

  localparam int W       = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;
  localparam int NREC    = 24;

  typedef struct {
    logic [2:0]  m;
    logic [23:0] d;
  } rec_s;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  rec_s exp_q[$];

  bitwise_result_packer_if #(.W(W), .CNT_W(CNT_W)) bus ();

  bitwise_result_packer #(
    .W       (W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] v, input logic [7:0] o, input logic [7:0] a,
                        input logic [7:0] x);
    bus.or_vld  = v[0]; bus.or_data  = o;
    bus.and_vld = v[1]; bus.and_data = a;
    bus.xor_vld = v[2]; bus.xor_data = x;
    @(posedge clk); #1;
    bus.or_vld = 1'b0; bus.and_vld = 1'b0; bus.xor_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.out_mask !== 3'b000) begin n_fail++; $display("FAIL reset_out_mask: got %b want 000", bus.out_mask); end
    n_checks++; if (bus.drop_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_staggered();
    bus.out_ready = 1'b1;
    strobe(3'b001, 8'h5A, 8'h00, 8'h00);
    idle(49);
    strobe(3'b010, 8'h00, 8'h0F, 8'h00);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stag_early_valid: got %b want 0", bus.out_valid); end
    idle(49);
    strobe(3'b100, 8'h00, 8'h00, 8'hF0);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stag_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 24'hF00F5A) begin n_fail++; $display("FAIL stag_data: got %h want f00f5a", bus.out_data); end
    n_checks++; if (bus.out_mask !== 3'b111) begin n_fail++; $display("FAIL stag_mask: got %b want 111", bus.out_mask); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stag_one_cycle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_simultaneous();
    strobe(3'b111, 8'hA5, 8'h00, 8'hFF);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 24'hFF00A5) begin n_fail++; $display("FAIL simul_data: got %h want ff00a5", bus.out_data); end
    n_checks++; if (bus.out_mask !== 3'b111) begin n_fail++; $display("FAIL simul_mask: got %b want 111", bus.out_mask); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_one_rec: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_timeout();
    strobe(3'b001, 8'h11, 8'h00, 8'h00);
    idle(TIMEOUT - 1);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", bus.out_valid); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_mask !== 3'b001) begin n_fail++; $display("FAIL tmo_mask: got %b want 001", bus.out_mask); end
    n_checks++; if (bus.out_data[7:0] !== 8'h11) begin n_fail++; $display("FAIL tmo_or_field: got %h want 11", bus.out_data[7:0]); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_duplicate();
    strobe(3'b001, 8'h01, 8'h00, 8'h00);
    idle(4);
    strobe(3'b001, 8'h02, 8'h00, 8'h00);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dup_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_mask !== 3'b001) begin n_fail++; $display("FAIL dup_mask: got %b want 001", bus.out_mask); end
    n_checks++; if (bus.out_data[7:0] !== 8'h01) begin n_fail++; $display("FAIL dup_or_field: got %h want 01", bus.out_data[7:0]); end
    @(posedge clk); #1;
    strobe(3'b010, 8'h00, 8'h33, 8'h00);
    strobe(3'b100, 8'h00, 8'h00, 8'h44);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_mask !== 3'b111) begin n_fail++; $display("FAIL dup_fresh_rec: got valid %b mask %b want 1 111", bus.out_valid, bus.out_mask); end
    n_checks++; if (bus.out_data !== 24'h443302) begin n_fail++; $display("FAIL dup_fresh_data: got %h want 443302", bus.out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [23:0] recs [3];
    recs[0] = 24'h332211; recs[1] = 24'h665544; recs[2] = 24'h998877;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strobe(3'b111, recs[k][7:0], recs[k][15:8], recs[k][23:16]);
    end
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.out_data !== recs[0]) begin n_fail++; $display("FAIL bp_head_hold: got %h want %h", bus.out_data, recs[0]); end
    strobe(3'b011, 8'hDE, 8'hAD, 8'h00);
    @(negedge clk);
    n_checks++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drop_cnt: got %0d want 2", bus.drop_cnt); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_mask !== 3'b111 || bus.out_data !== recs[k]) begin
        n_fail++; $display("FAIL bp_drain_%0d: got valid %b mask %b data %h want 1 111 %h", k, bus.out_valid, bus.out_mask, bus.out_data, recs[k]);
      end
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drained: got valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready); end
    n_checks++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drop_hold: got %0d want 2", bus.drop_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int got;
    bus.out_ready = 1'b1;
    got = 0;
    exp_q.delete();
    fork
      begin
        for (int r = 0; r < NREC; r++) begin
          logic [2:0] m;
          logic [7:0] fd [3];
          int         off [3];
          int         last;
          rec_s       e;
          m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 6)) : 3'b111;
          last = 0;
          for (int i = 0; i < 3; i++) begin
            fd[i]  = 8'($urandom);
            off[i] = $urandom_range(0, 8);
            if (m[i] && off[i] > last) last = off[i];
          end
          e.m = m;
          e.d = {fd[2], fd[1], fd[0]};
          exp_q.push_back(e);
          for (int c = 0; c <= last; c++) begin
            bus.or_data  = fd[0]; bus.or_vld  = m[0] && (off[0] == c);
            bus.and_data = fd[1]; bus.and_vld = m[1] && (off[1] == c);
            bus.xor_data = fd[2]; bus.xor_vld = m[2] && (off[2] == c);
            @(posedge clk); #1;
          end
          bus.or_vld = 1'b0; bus.and_vld = 1'b0; bus.xor_vld = 1'b0;
          if (m == 3'b111) idle($urandom_range(1, 4));
          else             idle(TIMEOUT + 3);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < NREC && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          if (bus.out_valid && bus.out_ready) begin
            rec_s        e;
            logic [23:0] mk;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_unexpected: got mask %b data %h want none", bus.out_mask, bus.out_data);
            end else begin
              e  = exp_q.pop_front();
              mk = {{8{e.m[2]}}, {8{e.m[1]}}, {8{e.m[0]}}};
              if (bus.out_mask !== e.m || (bus.out_data & mk) !== (e.d & mk)) begin
                n_fail++; $display("FAIL rand_rec_%0d: got mask %b data %h want mask %b data %h", got, bus.out_mask, bus.out_data & mk, e.m, e.d & mk);
              end
            end
            got++;
          end
        end
      end
    join
    n_checks++; if (got != NREC) begin n_fail++; $display("FAIL rand_count: got %0d records want %0d", got, NREC); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.out_ready = 1'b0;
    strobe(3'b111, 8'h12, 8'h34, 8'h56);
    strobe(3'b010, 8'h00, 8'h77, 8'h00);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", bus.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_drop_cnt: got %0d want 0", bus.drop_cnt); end
    n_checks++; if (bus.out_mask !== 3'b000) begin n_fail++; $display("FAIL rmid_out_mask: got %b want 000", bus.out_mask); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (TIMEOUT + 20) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_record: got %b want 0", seen); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.or_vld    = 1'b0; bus.or_data  = '0;
    bus.and_vld   = 1'b0; bus.and_data = '0;
    bus.xor_vld   = 1'b0; bus.xor_data = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_staggered();
    test_simultaneous();
    test_timeout();
    test_duplicate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitwise_result_packer.md
Name: bitwise_result_packer

Overview:
- Downstream consumer of the bitwise-op stage.
- That stage produces OR, AND and XOR results for one operand pair at staggered times, tens of cycles apart.
- This block collects the three fields into one record and buffers it in a 2-entry FIFO.
- It presents each record on a valid/ready output port, and flushes partial records on timeout or on a duplicate field.

Parameters:
- W, 8: width of each result field.
- TIMEOUT, 64: max cycles a partial record may wait for missing fields (≥2).
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- or_vld  in  1  OR field strobe.
- or_data  in  W  OR result.
- and_vld  in  1  AND field strobe.
- and_data  in  W  AND result.
- xor_vld  in  1  XOR field strobe.
- xor_data  in  W  XOR result.
- in_ready  out  1  block can accept strobes this cycle.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_data  out  3W  {xor, and, or}.
- out_mask  out  3  fields present {xor, and, or}; 3'b111 = complete.
- drop_cnt  out  CNT_W  strobes lost while in_ready=0 (saturating).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - in_ready=1, out_valid=0, out_data=0, out_mask=0, drop_cnt=0.
  - FIFO empty, state IDLE, timer=0.
  - Reset mid-record discards the partial record and the FIFO contents.
- States:
  - IDLE (no field held).
  - COLLECT (1–2 fields held).
  - STALL (record ready, FIFO full).
- Capture: a strobe with in_ready=1 latches its data into the held record and sets its mask bit. Multiple strobes in one cycle are all captured together.
- Completion: when the mask reaches 3'b111 (counting fields captured this cycle), the record is pushed at that same edge if the FIFO is not full. State → IDLE, mask cleared. out_valid=1 from the following cycle, so latency is 1 cycle from the last strobe edge to out_valid.
- Timeout:
  - timer is cleared on entry to COLLECT and on every captured strobe, and increments each COLLECT cycle.
  - At timer==TIMEOUT-1 the partial record is pushed with its partial mask. State → IDLE.
- Duplicate: a strobe for a field already held in COLLECT pushes the held record as partial. The new strobe's field then starts a fresh record; state stays COLLECT and timer resets. Other fields arriving in the same cycle join the fresh record.
- Stall:
  - If a push is required and the FIFO is full: state → STALL, in_ready=0 from the next cycle, record held.
  - Push happens on the first edge with a free FIFO slot. State then → IDLE and in_ready=1.
- Drops: in STALL each asserted strobe increments drop_cnt by 1 (up to 3 per cycle), saturating at all-ones. Dropped data is not captured.
- Output: out_data/out_mask show the FIFO head, stable while out_valid && !out_ready. Pop on out_valid && out_ready.
- Same-cycle push and pop with the FIFO full is allowed: the pop frees the slot and no STALL occurs.
- A timeout edge coinciding with the completing strobe gives a complete record, not a timeout.

Decomposition:
- Package bitwise_pack_pkg holds:
  - field index localparams OR_IDX=0, AND_IDX=1, XOR_IDX=2;
  - the state encoding IDLE/COLLECT/STALL;
  - the record struct {mask[2:0], xor, and, or} and its width function.
- One sub-module, bitwise_pack_fifo: 2-entry register FIFO with push/pop/full/empty, parameterised by record width.

Test Plan:
- Staggered completion: W=8, OR=8'h5A at t0, AND=8'h0F at t0+50, XOR=8'hF0 at t0+100, out_ready=1 → at t0+101 out_valid=1, out_data={F0,0F,5A}, out_mask=3'b111, for exactly 1 cycle.
- Simultaneous: all three strobes in one cycle with A5/00/FF → one record next cycle, mask 111, timer never runs.
- Timeout: OR=8'h11 only, TIMEOUT=64 → partial record emitted 64 cycles after the strobe with mask=3'b001 and in_ready staying 1.
- Duplicate: OR=8'h01, then OR=8'h02 five cycles later → record {x,x,01} mask 001 emitted; new record holds OR=02 and completes normally.
- Backpressure: out_ready=0 while 3 complete records are sent → FIFO holds 2; 3rd triggers STALL and in_ready=0. Strobe 2 fields in STALL → drop_cnt=2. Raise out_ready → three records emitted in order.
- Reset mid-collect: AND captured, assert rst_n=0 asynchronously mid-cycle → out_valid=0 and in_ready=1 immediately; after release, no stale record is ever emitted.
